// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM encoding, default sizes and the tie-break helper
// for the shared multiplier arbiter.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  // Requester 1 wins when it is the only one asking, or on a tie when
  // requester 1 was not the most recent grant (last_grant == 0).
  function automatic logic pick_req1(input logic v0, input logic v1,
                                     input logic last_grant);
    return v1 && (!v0 || !last_grant);
  endfunction

endpackage

// File: rtl/shift_add_mul_core.sv
// shift_add_mul_core: sequential unsigned multiplier, one shift-add step per
// cycle for WIDTH cycles. start loads the operands; done pulses for one cycle
// once product_o holds the full 2*WIDTH-bit result.
module shift_add_mul_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic               run_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc_q;    // {upper partial sum, remaining multiplier bits}

  logic [WIDTH:0]     sum_s;    // one extra bit keeps the carry of the add
  logic [2*WIDTH-1:0] acc_step_s;

  // One shift-add step: LSB of the multiplier selects adding b to the upper half,
  // then the whole accumulator (with carry) shifts right by one.
  always_comb begin
    sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      sum_s = sum_s + {1'b0, b_q};
    end else begin
      sum_s = sum_s;
    end
    acc_step_s = {sum_s, acc_q[WIDTH-1:1]};
  end

  // Operand load on start, WIDTH iterations while running, single-cycle done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      b_q    <= {WIDTH{1'b0}};
      acc_q  <= {(2*WIDTH){1'b0}};
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        run_q <= 1'b1;
        cnt_q <= {CNT_W{1'b0}};
        b_q   <= b_i;
        acc_q <= {{WIDTH{1'b0}}, a_i};
      end else if (run_q) begin
        acc_q <= acc_step_s;
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: two requesters share one sequential shift-add multiplier.
// Round-robin grant in IDLE, one multiply in flight, result held until taken.
// Optional build macro: MUL_SHARE_ZERO_BYPASS_EN -- an accepted pair with a
// zero operand skips the multiply and answers 0 one cycle after accept.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_data,
  input  logic               rsp_ready,
  output logic               busy
);

  mul_state_e         state_q;
  logic               last_grant_q;
  logic               id_q;
  logic               bypass_q;
  logic               rsp_valid_q;
  logic               rsp_id_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] rsp_data_q;

  logic               idle_s;
  logic               win1_s;
  logic               grant0_s;
  logic               grant1_s;
  logic               accept_s;
  logic               zero_hit_s;
  logic               start_s;
  logic               core_done_s;
  logic [WIDTH-1:0]   sel_a_s;
  logic [WIDTH-1:0]   sel_b_s;
  logic [2*WIDTH-1:0] core_product_s;

  // Grants are combinational from the valids and only offered in IDLE out of reset.
  assign idle_s   = (state_q == ST_IDLE) && !reset;
  assign win1_s   = pick_req1(req0_valid, req1_valid, last_grant_q);
  assign grant1_s = idle_s && win1_s;
  assign grant0_s = idle_s && req0_valid && !win1_s;
  assign accept_s = grant0_s || grant1_s;

  assign sel_a_s  = win1_s ? req1_a : req0_a;
  assign sel_b_s  = win1_s ? req1_b : req0_b;

`ifdef MUL_SHARE_ZERO_BYPASS_EN
  assign zero_hit_s = (sel_a_s == {WIDTH{1'b0}}) || (sel_b_s == {WIDTH{1'b0}});
`else
  assign zero_hit_s = 1'b0;
`endif

  // The core only runs for pairs that actually need the iterative multiply.
  assign start_s = accept_s && !zero_hit_s;

  shift_add_mul_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start_s),
    .a_i       (sel_a_s),
    .b_i       (sel_b_s),
    .done_o    (core_done_s),
    .product_o (core_product_s)
  );

  // Arbiter FSM: accept in IDLE, wait for the core in RUN, hold the response in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      bypass_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      rsp_data_q   <= {(2*WIDTH){1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
            id_q         <= grant1_s;
            last_grant_q <= grant1_s;
            bypass_q     <= zero_hit_s;
          end
        end
        ST_RUN: begin
          if (core_done_s || bypass_q) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_data_q  <= bypass_q ? {(2*WIDTH){1'b0}} : core_product_s;
            bypass_q    <= 1'b0;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          bypass_q    <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed + random stimulus, reference model for grant,
// latency and busy, scoreboard of (id, a*b) checked whenever rsp_valid is high.
module tb_mul_share_arbiter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_valid, req1_valid;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           rsp_valid, rsp_id, busy;
  logic           rsp_ready = 1'b1;
  logic [2*W-1:0] rsp_data;

  typedef struct {
    logic           id;
    logic [2*W-1:0] prod;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bit   m_busy = 1'b0;
  bit   m_lg   = 1'b1;
  int   m_acc  = 0;
  int   m_lat  = LAT;
  bit   rnd_bp  = 1'b0;
  bit   bp_hold = 1'b0;

  mul_share_arbiter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk64(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return {W{1'b0}};
      1:       return {W{1'b1}};
      default: return W'($urandom);
    endcase
  endfunction

  // Consumer readiness: held low on request, random in the random phase, else high.
  always @(posedge clk) begin
    #1;
    rsp_ready = rnd_bp ? 1'($urandom_range(0, 1)) : !bp_hold;
  end

  // Reference model: who should be granted, when the result is due, busy; pushes expectations.
  always @(negedge clk) begin : ref_model
    logic         e0, e1, erv, wid;
    logic [W-1:0] ea, eb;
    exp_t         ent;
    if (reset) begin
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_rsp_id", rsp_id, 1'b0);
      chk64("reset_rsp_data", rsp_data, {(2*W){1'b0}});
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_ready0", req0_ready, 1'b0);
      chk1("reset_ready1", req1_ready, 1'b0);
      m_busy = 1'b0;
      m_lg   = 1'b1;
      sbq.delete();
    end else begin
      // Tie goes to the requester not granted last time; otherwise the sole asker.
      if (req0_valid && req1_valid) begin
        e0 = !m_busy && m_lg;
        e1 = !m_busy && !m_lg;
      end else begin
        e0 = !m_busy && req0_valid;
        e1 = !m_busy && req1_valid;
      end
      erv = m_busy && ((cyc - m_acc) >= m_lat);
      chk1("ready0", req0_ready, e0);
      chk1("ready1", req1_ready, e1);
      chk1("busy", busy, m_busy);
      chk1("rsp_valid_timing", rsp_valid, erv);
      if (erv && rsp_ready) begin
        m_busy = 1'b0;
      end else if (e0 || e1) begin
        wid = e1;
        ea  = wid ? req1_a : req0_a;
        eb  = wid ? req1_b : req0_b;
        ent.id   = wid;
        ent.prod = {{W{1'b0}}, ea} * {{W{1'b0}}, eb};
        sbq.push_back(ent);
        m_busy = 1'b1;
        m_lg   = wid;
        m_acc  = cyc + 1;
`ifdef MUL_SHARE_ZERO_BYPASS_EN
        m_lat  = ((ea == {W{1'b0}}) || (eb == {W{1'b0}})) ? 1 : LAT;
`else
        m_lat  = LAT;
`endif
      end
    end
    cyc++;
  end

  // Scoreboard monitor: every cycle the DUT presents a result, compare against the oldest expectation.
  always @(negedge clk) begin : sb_monitor
    exp_t ent;
    if (!reset && rsp_valid) begin
      chk1("rsp_expected", 1'(sbq.size() != 0), 1'b1);
      if (sbq.size() != 0) begin
        ent = sbq[0];
        chk1("rsp_id", rsp_id, ent.id);
        chk64("rsp_data", rsp_data, ent.prod);
        if (rsp_ready) begin
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input bit which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((!which && req0_valid && req0_ready) || (which && req1_valid && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!which) begin
      req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom);
    end else begin
      req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom);
    end
    chk1(which ? "accept1_wait" : "accept0_wait", ok, 1'b1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("drain_wait", ok, 1'b1);
  endtask

  task automatic single(input bit which, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    @(posedge clk);
    #1;
    if (!which) begin
      req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    wait_ready(which, ok);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit       ok;
    bit       g0, g1;
    logic [1:0] v;
    // Both requesters valid out of reset: req0 first, then req1.
    reset = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd4;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    wait_ready(1'b0, ok);
    wait_ready(1'b1, ok);
    wait_idle();

    // Next tie goes back to req0.
    @(posedge clk);
    #1;
    req0_a = rand_op(); req0_b = rand_op(); req0_valid = 1'b1;
    req1_a = rand_op(); req1_b = rand_op(); req1_valid = 1'b1;
    wait_ready(1'b0, ok);
    wait_ready(1'b1, ok);
    wait_idle();

    // Single request 7*6, with a req1 pulse during RUN that must be ignored.
    @(posedge clk);
    #1 req0_a = 32'd7; req0_b = 32'd6; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    repeat (5) @(posedge clk);
    #1 req1_valid = 1'b1; req1_a = 32'd11; req1_b = 32'd13;
    repeat (3) @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_idle();

    // Backpressure: consumer stalls 10 cycles while req1 is waiting.
    @(posedge clk);
    #1 bp_hold = 1'b1;
    req0_a = W'($urandom); req0_b = W'($urandom); req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    req1_a = W'($urandom); req1_b = W'($urandom); req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("bp_rsp_wait", ok, 1'b1);
    repeat (10) @(posedge clk);
    #1 bp_hold = 1'b0;
    wait_ready(1'b1, ok);
    wait_idle();

    // Extremes.
    single(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    single(1'b1, 32'h8000_0000, 32'd2);

    // Reset in the middle of RUN, then a normal req1 request.
    @(posedge clk);
    #1 req0_a = 32'h1234_5678; req0_b = 32'h0000_0321; req0_valid = 1'b1;
    wait_ready(1'b0, ok);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    single(1'b1, 32'h0000_BEEF, 32'h0001_0003);

    // Zero operand.
    single(1'b0, 32'd0, 32'd9);

    // Random phase with random consumer readiness.
    rnd_bp = 1'b1;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      #1;
      v = 2'($urandom_range(1, 3));
      if (!req0_valid) begin req0_a = rand_op(); req0_b = rand_op(); end
      if (!req1_valid) begin req1_a = rand_op(); req1_b = rand_op(); end
      req0_valid = v[0];
      req1_valid = v[1];
      for (int k = 0; k < 500 && (req0_valid || req1_valid); k++) begin
        @(negedge clk);
        g0 = req0_valid && req0_ready;
        g1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (g0) begin req0_valid = 1'b0; req0_a = W'($urandom); req0_b = W'($urandom); end
        if (g1) begin req1_valid = 1'b0; req1_a = W'($urandom); req1_b = W'($urandom); end
      end
      chk1("rand_accept_wait", req0_valid || req1_valid, 1'b0);
    end
    wait_idle();
    rnd_bp = 1'b0;
    repeat (2) @(posedge clk);

    chk1("scoreboard_empty", 1'(sbq.size() == 0), 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
